// File: rtl/fpga_led_top.sv
// fpga_led_top: SPI-slave frame receiver feeding a WS2812-style LED chain driver.
// Ports: CLK_50M, RST (sync, active-high), SPI slave (SYS_SPI_SCK/MOSI/MISO,
//   RP_SPI_CE0N), PMOD4[0] LED data. Optional MISO echo: FPGA_LED_MISO_ECHO_EN.
// TIMEOUT_CYC is the CE0N-high resync interval (65536 cycles in the product).
`timescale 1ns/1ps
module fpga_led_top #(
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       SYS_SPI_SCK,
  input  logic       SYS_SPI_MOSI,
  input  logic       RP_SPI_CE0N,
  output logic       SYS_SPI_MISO,
  output logic [0:0] PMOD4
);

  localparam int N       = 3 * IMG_WIDTH * IMG_HEIGHT;
  localparam int AW      = (N > 1) ? $clog2(N) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int T_BIT   = 62;
  localparam int T1H     = 40;
  localparam int T0H     = 20;
  localparam int T_LATCH = 3000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  logic [1:0]    r_sck_s;
  logic [1:0]    r_mosi_s;
  logic [1:0]    r_cs_s;
  logic          r_sck_q;
  logic [2:0]    r_bitcnt;
  logic [6:0]    r_shift;
  logic [AW-1:0] r_wr_ptr;
  logic          r_frame_rdy;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_mem [N];
  logic [7:0]    r_rd_data;

  logic          w_sck;
  logic          w_cs_n;
  logic          w_mosi;
  logic          w_rise;
  logic          w_done;
  logic          w_to;
  logic [7:0]    w_byte;

  state_t        r_state;
  state_t        w_state_nx;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_nx;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nx;
  logic [11:0]   r_tcnt;
  logic [11:0]   w_tcnt_nx;
  logic [7:0]    r_shreg;
  logic [7:0]    w_shreg_nx;
  logic          r_ld_ph;
  logic          w_ld_ph_nx;
  logic          w_frm_take;
  logic [11:0]   w_th;
  logic          r_led;

  assign w_sck  = r_sck_s[1];
  assign w_cs_n = r_cs_s[1];
  assign w_mosi = r_mosi_s[1];
  assign w_rise = w_sck & ~r_sck_q & ~w_cs_n;
  assign w_byte = {r_shift, w_mosi};
  assign w_done = w_rise & (r_bitcnt == 3'd7);
  assign w_to   = w_cs_n & (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_sck_s  <= 2'b11;
      r_mosi_s <= 2'b00;
      r_cs_s   <= 2'b11;
      r_sck_q  <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[0], SYS_SPI_SCK};
      r_mosi_s <= {r_mosi_s[0], SYS_SPI_MOSI};
      r_cs_s   <= {r_cs_s[0], RP_SPI_CE0N};
      r_sck_q  <= r_sck_s[1];
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_wr_ptr    <= '0;
      r_frame_rdy <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (w_cs_n)
        r_bitcnt <= '0;
      else if (w_rise)
        r_bitcnt <= r_bitcnt + 3'd1;
      if (w_rise)
        r_shift <= w_byte[6:0];
      // counter saturates so a long idle clears wr_ptr only once
      if (!w_cs_n)
        r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYC))
        r_to_cnt <= r_to_cnt + TW'(1);
      if (w_done)
        r_wr_ptr <= (r_wr_ptr == AW'(N - 1)) ? '0 : r_wr_ptr + AW'(1);
      else if (w_to)
        r_wr_ptr <= '0;
      // a new frame arriving as the FSM takes the old one stays pending
      if (w_done && (r_wr_ptr == AW'(N - 1)))
        r_frame_rdy <= 1'b1;
      else if (w_frm_take)
        r_frame_rdy <= 1'b0;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (w_done)
      r_mem[r_wr_ptr] <= w_byte;
    r_rd_data <= r_mem[r_rd_ptr];
  end

  assign w_th = r_shreg[r_bit_idx] ? 12'(T1H) : 12'(T0H);

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= '0;
      r_bit_idx <= '0;
      r_tcnt    <= '0;
      r_shreg   <= '0;
      r_ld_ph   <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rd_ptr  <= w_rd_ptr_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_tcnt    <= w_tcnt_nx;
      r_shreg   <= w_shreg_nx;
      r_ld_ph   <= w_ld_ph_nx;
      r_led     <= (w_state_nx == S_HIGH);
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_rd_ptr_nx  = r_rd_ptr;
    w_bit_idx_nx = r_bit_idx;
    w_tcnt_nx    = r_tcnt + 12'd1;
    w_shreg_nx   = r_shreg;
    w_ld_ph_nx   = r_ld_ph;
    w_frm_take   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tcnt_nx = '0;
        if (r_frame_rdy) begin
          w_frm_take  = 1'b1;
          w_state_nx  = S_LOAD;
          w_rd_ptr_nx = '0;
          w_ld_ph_nx  = 1'b0;
        end
      end
      S_LOAD: begin
        // phase 0 waits out the RAM read latency
        w_tcnt_nx = '0;
        if (!r_ld_ph) begin
          w_ld_ph_nx = 1'b1;
        end else begin
          w_ld_ph_nx   = 1'b0;
          w_shreg_nx   = r_rd_data;
          w_bit_idx_nx = 3'd7;
          w_state_nx   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_tcnt == w_th - 12'd1) begin
          w_tcnt_nx  = '0;
          w_state_nx = S_LOW;
        end
      end
      S_LOW: begin
        if (r_tcnt == 12'(T_BIT) - w_th - 12'd1) begin
          w_tcnt_nx = '0;
          if (r_bit_idx != 3'd0) begin
            w_bit_idx_nx = r_bit_idx - 3'd1;
            w_state_nx   = S_HIGH;
          end else if (r_rd_ptr == AW'(N - 1)) begin
            w_state_nx = S_LATCH;
          end else begin
            w_rd_ptr_nx = r_rd_ptr + AW'(1);
            w_ld_ph_nx  = 1'b0;
            w_state_nx  = S_LOAD;
          end
        end
      end
      S_LATCH: begin
        if (r_tcnt == 12'(T_LATCH - 1)) begin
          w_tcnt_nx  = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign PMOD4[0] = r_led;

`ifdef FPGA_LED_MISO_ECHO_EN
  logic       w_fall;
  logic [7:0] r_echo;
  logic       r_miso;

  assign w_fall = ~w_sck & r_sck_q & ~w_cs_n;

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_echo <= '0;
      r_miso <= 1'b0;
    end else begin
      if (w_done)
        r_echo <= w_byte;
      else if (w_fall)
        r_echo <= {r_echo[6:0], 1'b0};
      if (w_cs_n)
        r_miso <= 1'b0;
      else if (w_fall)
        r_miso <= r_echo[7];
    end
  end

  assign SYS_SPI_MISO = r_miso;
`else
  assign SYS_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_led_top.sv
// tb_fpga_led_top: random SPI frames against a frame-snapshot model;
// LED line decoded by pulse widths and compared byte by byte.
`timescale 1ns/1ps
module tb_fpga_led_top;
  localparam int W    = 3;
  localparam int H    = 1;
  localparam int N    = 3 * W * H;
  localparam int TO   = 2048;
  localparam int HALF = 301;

  typedef logic [8*N-1:0] frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b1;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic [0:0] led;

  always #10 clk = ~clk;

  fpga_led_top #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .TIMEOUT_CYC(TO)
  ) u_dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .SYS_SPI_SCK (sck),
    .SYS_SPI_MOSI(mosi),
    .RP_SPI_CE0N (cs_n),
    .SYS_SPI_MISO(miso),
    .PMOD4       (led)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic [7:0] m_buf [N];
  int         m_wp = 0;
  frame_t     fq[$];
  time        t_cs_rise = 0;

  task automatic model_write(input logic [7:0] b);
    frame_t f;
    m_buf[m_wp] = b;
    if (m_wp == N - 1) begin
      for (int i = 0; i < N; i++) f[i*8 +: 8] = m_buf[i];
      fq.push_back(f);
      m_wp = 0;
    end else begin
      m_wp++;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
    if (($time - t_cs_rise) > TO * 20) m_wp = 0;
    cs_n = 1'b0;
    #HALF;
    for (int i = 7; i >= 0; i--) begin
      sck  = 1'b0;
      mosi = b[i];
      #HALF;
      rx[i] = miso;
      sck = 1'b1;
      if (i == 0) model_write(b);
      #HALF;
    end
    cs_n = 1'b1;
    t_cs_rise = $time;
    #HALF;
  endtask

  task automatic spi_partial(input int edges);
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < edges; i++) begin
      sck  = 1'b0;
      mosi = 1'b1;
      #HALF;
      sck = 1'b1;
      #HALF;
    end
    cs_n = 1'b1;
    t_cs_rise = $time;
    #(2 * HALF);
  endtask

  // LED line monitor
  int         run = 0;
  logic       prev = 1'b0;
  bit         in_frame = 0;
  int         bit_no = 0;
  int         last_hi = 0;
  int         frames_seen = 0;
  int         rises = 0;
  bit         expect_b2b = 0;
  frame_t     cur = '0;
  logic [7:0] acc = '0;

  task automatic on_low(input int l);
    rises++;
    if (!in_frame) begin
      if (frames_seen > 0) check("latch_gap", int'(l >= 3000), 1);
      if (expect_b2b) begin
        check("b2b_gap", int'(l <= 3070), 1);
        expect_b2b = 0;
      end
      check("frame_queued", int'(fq.size() != 0), 1);
      cur = (fq.size() != 0) ? fq.pop_front() : '0;
      in_frame = 1;
      bit_no = 0;
    end else begin
      check("bit_period", last_hi + l, (bit_no % 8 == 0) ? 64 : 62);
    end
  endtask

  task automatic on_high(input int h);
    int   byte_i;
    logic eb;
    last_hi = h;
    byte_i = bit_no / 8;
    eb = cur[byte_i*8 + 7 - (bit_no % 8)];
    check("t_high", h, eb ? 40 : 20);
    acc = {acc[6:0], (h >= 30)};
    bit_no++;
    if (bit_no % 8 == 0) check("byte", acc, cur[byte_i*8 +: 8]);
    if (bit_no == 8 * N) begin
      in_frame = 0;
      frames_seen++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      prev = 1'b0;
      in_frame = 0;
      expect_b2b = 0;
    end else begin
      if (led[0] == prev) begin
        run++;
      end else begin
        if (prev) on_high(run);
        else on_low(run);
        run = 1;
      end
      prev = led[0];
    end
  end

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (frames_seen >= target) break;
      @(negedge clk);
    end
    check("frames", frames_seen, target);
  endtask

  logic [7:0] rx;
  logic [7:0] fr [N];
  int         r0;

  initial begin
    repeat (5) @(negedge clk) begin
      sck  = 1'($urandom);
      mosi = 1'($urandom);
      cs_n = 1'($urandom);
    end
    sck  = 1'b1;
    cs_n = 1'b1;
    check("rst_led", int'(led), 0);
    check("rst_miso", int'(miso), 0);
    @(negedge clk);
    rst = 1'b0;
    t_cs_rise = $time;
    m_wp = 0;
    repeat (5000) @(negedge clk);
    check("idle_rises", rises, 0);

    spi_byte(8'hA5, rx);
    for (int i = 1; i < N; i++) spi_byte(8'h00, rx);
    wait_frames(1, 15000);

    spi_partial(5);
    spi_byte(8'h81, rx);
    for (int i = 1; i < N; i++) spi_byte(8'($urandom), rx);
    wait_frames(2, 15000);

    for (int i = 0; i < 5; i++) spi_byte(8'($urandom), rx);
    repeat (TO + 1000) @(negedge clk);
    for (int i = 0; i < N; i++) spi_byte(8'($urandom), rx);
    wait_frames(3, 15000);
    repeat (4000) @(negedge clk);
    check("one_frame", frames_seen, 3);

    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    for (int i = 0; i < N; i++) spi_byte(fr[i], rx);
    for (int i = 0; i < 2000 && !in_frame; i++) @(negedge clk);
    check("tx_started", int'(in_frame), 1);
    expect_b2b = 1;
    for (int i = 0; i < N; i++) spi_byte(fr[i], rx);
    wait_frames(5, 20000);

    spi_byte(8'h3C, rx);
    spi_byte(8'h00, rx);
`ifdef FPGA_LED_MISO_ECHO_EN
    check("miso_echo", rx, 8'h3C);
`else
    check("miso_tied", rx, 8'h00);
`endif

    for (int i = 2; i < N; i++) spi_byte(8'($urandom), rx);
    for (int i = 0; i < 5000; i++) begin
      if (in_frame && bit_no >= 12 && led[0]) break;
      @(negedge clk);
    end
    check("pre_abort_led", int'(led), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", int'(led), 0);
    @(negedge clk);
    rst = 1'b0;
    fq.delete();
    m_wp = 0;
    r0 = rises;
    repeat (4000) @(negedge clk);
    check("post_rst_quiet", rises - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
